bch_checker: RTL and testbench
==============================

Name: bch_checker

Overview:
- Receives serial BCH(63,51) codewords from the channel demodulator/slicer, one bit per accepted handshake.
- Recomputes the remainder against generator g(x)=x^12+x^10+x^8+x^5+x^4+x^3+1 (13'h1539).
- Strips the 12 parity bits and presents the 51 data bits in parallel, together with the 12-bit syndrome and an error flag.
- Sits directly downstream of the BCH encoder's serial output across the link; feeds the deframer.

Parameters:
- N, 63, codeword length in bits
- K, 51, data bits per codeword
- GEN_POLY, 13'h1539, generator polynomial; bit 12 is implicit MSB

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- valid_in  input  1  upstream has a bit on data_in
- ready_out  output  1  block accepts a bit this cycle
- data_in  input  1  serial codeword bit, x^62 coefficient first
- sof_in  input  1  start-of-frame; qualified by valid_in&&ready_out
- valid_out  output  1  parallel result available
- ready_in  input  1  downstream accepts result
- data_out_all  output  51  data bits; [50] = first received bit
- syndrome_out  output  12  remainder r(x) mod g(x)
- err_out  output  1  syndrome_out != 0
- frame_abort  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (rst=0, async): state=RECV, bit counter=0, remainder=0, data shift register=0, all outputs 0 except ready_out=1.
- Bit accept = valid_in && ready_out.
- States:
  - RECV: ready_out=1, valid_out=0.
  - HOLD: ready_out=0, valid_out=1.
- RECV, each accepted bit b:
  - rem <= {rem[10:0],b} ^ (rem[11] ? GEN_POLY[11:0] : 12'h0).
  - If counter<K, data_sr <= {data_sr[49:0],b}.
  - counter <= counter+1.
- On acceptance of bit with counter==62:
  - Next cycle: syndrome_out = final remainder (including that bit), data_out_all = data_sr, err_out = |syndrome, valid_out=1.
  - state=HOLD; counter, rem cleared.
  - Latency: 1 cycle from last-bit accept to valid_out.
- HOLD: outputs stable while ready_in=0. When ready_in=1: valid_out<=0, state<=RECV, so ready_out=1 on the following cycle. This gives a minimum 1-cycle input bubble per frame.
- sof_in on an accepted bit:
  - The bit is treated as bit 0 of a new frame: rem restarts from 0 with that bit, data_sr loads it, counter<=1.
  - If counter was nonzero, frame_abort pulses for 1 cycle; the partial frame is dropped and no valid_out is produced for it.
  - sof_in with counter==0 has no abort.
- sof_in without valid_in is ignored. sof_in in HOLD is not possible because the bit is not accepted.
- valid_in=0 in RECV: counter/rem/data_sr hold; gaps of any length are allowed.
- Reset mid-frame or in HOLD: immediate return to reset values; the held result is lost and no frame_abort is generated.
- Counter width is 6 bits, with no wrap past 62 (transition to HOLD).

Optional Feature:
- Macro BCH_CHECKER_STATS_EN.
- Defined: adds outputs frame_cnt[15:0], err_cnt[15:0], abort_cnt[15:0], all reset to 0.
  - frame_cnt increments when a result enters HOLD.
  - err_cnt increments also when err_out is set for that result.
  - abort_cnt increments on each frame_abort.
  - All counters saturate at 16'hFFFF.
  - Input clr_stats (1 bit, synchronous) zeroes all three; a clear coinciding with an increment yields 0.
- Undefined: these ports and their logic are absent; core behaviour is identical.

Test Plan:
- All-zero codeword, 63 bits, valid_in continuous, ready_in=1 -> one cycle after the 63rd bit: valid_out=1, data_out_all=51'h0, syndrome_out=12'h000, err_out=0.
- Data 51'h1 followed by parity 12'h539 (MSB first) -> data_out_all=51'h1, syndrome_out=12'h000, err_out=0.
- Same frame with last bit flipped (parity 12'h538) -> syndrome_out=12'h001, err_out=1, data_out_all=51'h1.
- ready_in=0 for 10 cycles after valid_out -> outputs stable, ready_out=0. Second frame's first bit is accepted only on the 2nd cycle after ready_in rises. Second frame decodes correctly.
- sof_in asserted on bit 30 of a frame, then 62 more bits of an all-zero codeword -> frame_abort pulses once on the cycle after the sof bit. Exactly one valid_out, with syndrome 0.
- rst pulsed low at bit 40, then a full valid codeword -> no frame_abort, exactly one valid_out, err_out=0. With BCH_CHECKER_STATS_EN: frame_cnt=1, err_cnt=0, abort_cnt=0.

Source files
------------

// File: rtl/bch_checker_if.sv
// Stream-in / result-out handshake bundle for the serial BCH(63,51) checker.
interface bch_checker_if #(
  parameter int unsigned K = 51
);
  logic         valid_in;
  logic         ready_out;
  logic         data_in;
  logic         sof_in;
  logic         valid_out;
  logic         ready_in;
  logic [K-1:0] data_out_all;
  logic [11:0]  syndrome_out;
  logic         err_out;
  logic         frame_abort;

  modport slave (
    input  valid_in, data_in, sof_in, ready_in,
    output ready_out, valid_out, data_out_all, syndrome_out, err_out, frame_abort
  );

  modport master (
    output valid_in, data_in, sof_in, ready_in,
    input  ready_out, valid_out, data_out_all, syndrome_out, err_out, frame_abort
  );
endinterface

// File: rtl/bch_checker.sv
// Serial BCH(63,51) checker: recomputes the remainder, strips parity and presents data + syndrome.
// Optional statistics counters are enabled with `define BCH_CHECKER_STATS_EN.
module bch_checker #(
  parameter int unsigned N        = 63,
  parameter int unsigned K        = 51,
  parameter logic [12:0] GEN_POLY = 13'h1539
) (
  input  logic         clk,
  input  logic         rst,
  bch_checker_if.slave bus
`ifdef BCH_CHECKER_STATS_EN
  ,
  input  logic         clr_stats,
  output logic [15:0]  frame_cnt,
  output logic [15:0]  err_cnt,
  output logic [15:0]  abort_cnt
`endif
);

  localparam logic [5:0] KCnt    = 6'(K);
  localparam logic [5:0] LastCnt = 6'(N - 1);

  typedef enum logic [0:0] {StRecv, StHold} state_e;

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [11:0]  rem_q, rem_d, rem_step;
  logic [K-1:0] sr_q, sr_d;
  logic [K-1:0] dout_q, dout_d;
  logic [11:0]  syn_q, syn_d;
  logic         err_q, err_d;
  logic         abort_q, abort_d;
  logic         accept;
  logic         enter_hold;

  assign accept = bus.valid_in && (state_q == StRecv);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    sr_d       = sr_q;
    dout_d     = dout_q;
    syn_d      = syn_q;
    err_d      = err_q;
    abort_d    = 1'b0;
    enter_hold = 1'b0;
    rem_step   = {rem_q[10:0], bus.data_in} ^ (rem_q[11] ? GEN_POLY[11:0] : 12'h000);

    unique case (state_q)
      StRecv: begin
        if (accept) begin
          if (bus.sof_in) begin
            // A start bit always begins a fresh frame; any partial frame is dropped.
            rem_d   = {11'b0, bus.data_in};
            sr_d    = {{(K-1){1'b0}}, bus.data_in};
            cnt_d   = 6'd1;
            abort_d = (cnt_q != 6'd0);
          end else begin
            rem_d = rem_step;
            if (cnt_q < KCnt) sr_d = {sr_q[K-2:0], bus.data_in};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LastCnt) begin
              syn_d      = rem_step;
              dout_d     = sr_q;
              err_d      = |rem_step;
              state_d    = StHold;
              cnt_d      = 6'd0;
              rem_d      = 12'h000;
              enter_hold = 1'b1;
            end
          end
        end
      end
      StHold: begin
        if (bus.ready_in) state_d = StRecv;
      end
      default: state_d = StRecv;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRecv;
      cnt_q   <= 6'd0;
      rem_q   <= 12'h000;
      sr_q    <= '0;
      dout_q  <= '0;
      syn_q   <= 12'h000;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign bus.ready_out    = (state_q == StRecv);
  assign bus.valid_out    = (state_q == StHold);
  assign bus.data_out_all = dout_q;
  assign bus.syndrome_out = syn_q;
  assign bus.err_out      = err_q;
  assign bus.frame_abort  = abort_q;

`ifdef BCH_CHECKER_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q, abort_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
      abort_cnt_q <= 16'h0000;
    end else if (clr_stats) begin
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
      abort_cnt_q <= 16'h0000;
    end else begin
      if (enter_hold && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (enter_hold && err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      if (abort_d && abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_bch_checker.sv
// Directed self-checking bench for bch_checker with hand-computed BCH(63,51) codewords.
module tb_bch_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bch_checker_if bus ();

`ifdef BCH_CHECKER_STATS_EN
  logic        clr_stats = 1'b0;
  logic [15:0] frame_cnt, err_cnt, abort_cnt;
`endif

  bch_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef BCH_CHECKER_STATS_EN
    ,
    .clr_stats (clr_stats),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_abort = 0;
  logic vprev = 1'b0;

  always @(negedge clk) begin
    if (bus.valid_out && !vprev) n_valid++;
    if (bus.frame_abort) n_abort++;
    vprev = bus.valid_out;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one bit and waits until it is accepted; reports edges spent.
  task automatic send_bit(input logic b, input logic sof, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    bus.sof_in   = sof;
    while (!acc && waited < 20) begin
      acc = bus.ready_out;
      tick();
      waited++;
    end
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
    bus.sof_in = 1'b0;
  endtask

  task automatic send_bits(input logic [62:0] cw, input int first, input int last);
    int w;
    for (int i = first; i <= last; i++) send_bit(cw[62-i], 1'b0, w);
  endtask

  logic [62:0] cw;
  int w, v0, a0;

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
    bus.sof_in   = 1'b0;
    bus.ready_in = 1'b1;
    #12;
    check_eq("rst_ready", 64'(bus.ready_out), 64'd1);
    check_eq("rst_valid", 64'(bus.valid_out), 64'd0);
    check_eq("rst_data", 64'(bus.data_out_all), 64'd0);
    check_eq("rst_syn", 64'(bus.syndrome_out), 64'd0);
    check_eq("rst_err", 64'(bus.err_out), 64'd0);
    check_eq("rst_abort", 64'(bus.frame_abort), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // All-zero codeword
    cw = 63'h0;
    send_bits(cw, 0, 62);
    check_eq("zero_valid", 64'(bus.valid_out), 64'd1);
    check_eq("zero_data", 64'(bus.data_out_all), 64'd0);
    check_eq("zero_syn", 64'(bus.syndrome_out), 64'h000);
    check_eq("zero_err", 64'(bus.err_out), 64'd0);
    bus.valid_in = 1'b0;
    tick();
    check_eq("zero_release_valid", 64'(bus.valid_out), 64'd0);
    check_eq("zero_release_ready", 64'(bus.ready_out), 64'd1);

    // g(x) itself: data 1, parity 0x539
    cw = {51'h1, 12'h539};
    send_bits(cw, 0, 62);
    check_eq("g_valid", 64'(bus.valid_out), 64'd1);
    check_eq("g_data", 64'(bus.data_out_all), 64'h1);
    check_eq("g_syn", 64'(bus.syndrome_out), 64'h000);
    check_eq("g_err", 64'(bus.err_out), 64'd0);
    bus.valid_in = 1'b0;
    tick();

    // Last bit flipped
    cw = {51'h1, 12'h538};
    send_bits(cw, 0, 62);
    check_eq("flip_data", 64'(bus.data_out_all), 64'h1);
    check_eq("flip_syn", 64'(bus.syndrome_out), 64'h001);
    check_eq("flip_err", 64'(bus.err_out), 64'd1);
    bus.valid_in = 1'b0;
    tick();

    // Backpressure: hold for 10 cycles, then a second frame (data 7, parity 0xE96)
    bus.ready_in = 1'b0;
    cw = {51'h1, 12'h539};
    send_bits(cw, 0, 62);
    bus.valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_valid", 64'(bus.valid_out), 64'd1);
      check_eq("hold_ready", 64'(bus.ready_out), 64'd0);
      check_eq("hold_data", 64'(bus.data_out_all), 64'h1);
      check_eq("hold_syn", 64'(bus.syndrome_out), 64'h000);
      tick();
    end
    bus.ready_in = 1'b1;
    cw = {51'h7, 12'hE96};
    send_bit(cw[62], 1'b0, w);
    check_eq("bubble_edges", 64'(w), 64'd2);
    send_bits(cw, 1, 62);
    check_eq("f2_valid", 64'(bus.valid_out), 64'd1);
    check_eq("f2_data", 64'(bus.data_out_all), 64'h7);
    check_eq("f2_syn", 64'(bus.syndrome_out), 64'h000);
    check_eq("f2_err", 64'(bus.err_out), 64'd0);
    bus.valid_in = 1'b0;
    tick();

    // sof on bit 30 restarts the frame
    v0 = n_valid;
    a0 = n_abort;
    cw = 63'h0;
    send_bits(cw, 0, 29);
    send_bit(1'b0, 1'b1, w);
    check_eq("sof_abort_pulse", 64'(bus.frame_abort), 64'd1);
    send_bit(1'b0, 1'b0, w);
    check_eq("sof_abort_clear", 64'(bus.frame_abort), 64'd0);
    check_eq("sof_no_early_valid", 64'(bus.valid_out), 64'd0);
    send_bits(cw, 2, 62);
    check_eq("sof_valid", 64'(bus.valid_out), 64'd1);
    check_eq("sof_syn", 64'(bus.syndrome_out), 64'h000);
    bus.valid_in = 1'b0;
    tick();
    tick();
    check_eq("sof_valid_count", 64'(n_valid - v0), 64'd1);
    check_eq("sof_abort_count", 64'(n_abort - a0), 64'd1);

    // Reset mid-frame at bit 40, then a valid codeword (data 2, parity 0xA72)
    cw = {51'h7, 12'hE96};
    send_bits(cw, 0, 39);
    bus.valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_ready", 64'(bus.ready_out), 64'd1);
    check_eq("midrst_valid", 64'(bus.valid_out), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    v0 = n_valid;
    a0 = n_abort;
    cw = {51'h2, 12'hA72};
    send_bits(cw, 0, 62);
    check_eq("postrst_valid", 64'(bus.valid_out), 64'd1);
    check_eq("postrst_data", 64'(bus.data_out_all), 64'h2);
    check_eq("postrst_syn", 64'(bus.syndrome_out), 64'h000);
    check_eq("postrst_err", 64'(bus.err_out), 64'd0);
    bus.valid_in = 1'b0;
    tick();
    tick();
    check_eq("postrst_valid_count", 64'(n_valid - v0), 64'd1);
    check_eq("postrst_abort_count", 64'(n_abort - a0), 64'd0);
`ifdef BCH_CHECKER_STATS_EN
    check_eq("stats_frame", 64'(frame_cnt), 64'd1);
    check_eq("stats_err", 64'(err_cnt), 64'd0);
    check_eq("stats_abort", 64'(abort_cnt), 64'd0);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check_eq("stats_clr_frame", 64'(frame_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
